// File: rtl/alsu_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : alsu_arbiter_if
// Brief    : Requester, result and ALSU-side signals of the ALSU arbiter.
// Revision : 1.0
//==============================================================================
interface alsu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] cmd0;
  logic [15:0] cmd1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [5:0]  result;
  logic        err;
  logic [2:0]  alsu_A;
  logic [2:0]  alsu_B;
  logic [2:0]  alsu_opcode;
  logic        alsu_cin;
  logic        alsu_serial_in;
  logic        alsu_direction;
  logic        alsu_red_op_A;
  logic        alsu_red_op_B;
  logic        alsu_bypass_A;
  logic        alsu_bypass_B;
  logic [5:0]  alsu_out;

  // Arbiter side
  modport slave (
    input  req0, req1, cmd0, cmd1, alsu_out,
    output gnt0, gnt1, done0, done1, result, err,
    output alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
    output alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B
  );

  // Requesters plus ALSU side
  modport master (
    output req0, req1, cmd0, cmd1, alsu_out,
    input  gnt0, gnt1, done0, done1, result, err,
    input  alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
    input  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B
  );
endinterface
`default_nettype wire

// File: rtl/alsu_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : alsu_arbiter
// Brief    : Two-requester round-robin front end for a pipelined ALSU, one
//            transaction in flight. Macro ALSU_ARB_PRECHECK_EN rejects invalid
//            commands at grant instead of forwarding them to the ALSU.
// Revision : 1.0
//==============================================================================
module alsu_arbiter #(
  parameter int LAT     = 2,   // ALSU latency in edges, must be >= 2
  parameter int HOLDOFF = 16   // blocked cycles after an invalid command, >= 1
) (
  input wire            clk,
  input wire            rst,
  alsu_arbiter_if.slave bus
);

  localparam int c_CNT_MAX = (LAT > HOLDOFF) ? LAT : HOLDOFF;
  localparam int c_CW      = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(LAT - 2);
  localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } cmd_t;

  // Opcodes 110/111 are illegal; reduction is only defined for AND/XOR.
  function automatic logic cmd_invalid(input cmd_t c);
    logic opc_bad;
    logic red_bad;
    opc_bad = (c.opcode[2:1] == 2'b11);
    red_bad = (c.red_op_a | c.red_op_b) & (c.opcode[2:1] != 2'b00);
    return opc_bad | red_bad;
  endfunction

  state_t          state_q,    state_d;
  logic [c_CW-1:0] cnt_q,      cnt_d;
  logic            owner_q,    owner_d;
  logic            last_q,     last_d;
  logic            inv_q,      inv_d;
  logic            gnt0_q,     gnt0_d;
  logic            gnt1_q,     gnt1_d;
  logic            done0_q,    done0_d;
  logic            done1_q,    done1_d;
  logic [5:0]      result_q,   result_d;
  logic            err_q,      err_d;
  cmd_t            alsu_cmd_q, alsu_cmd_d;

  logic            w_any_req;
  logic            w_winner;
  cmd_t            w_win_cmd;
  logic            w_win_inv;

  // Round robin: a lone request wins, contention goes to the one not granted last.
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_winner = ~last_q;
    end else begin
      w_winner = bus.req1 & ~bus.req0;
    end
    w_win_cmd = w_winner ? cmd_t'(bus.cmd1) : cmd_t'(bus.cmd0);
    w_win_inv = cmd_invalid(w_win_cmd);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    inv_d      = inv_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    result_d   = result_q;
    err_d      = err_q;
    alsu_cmd_d = alsu_cmd_q;

    case (state_q)
      S_IDLE: begin
        alsu_cmd_d = '0;
        if (w_any_req) begin
          owner_d = w_winner;
          last_d  = w_winner;
          inv_d   = w_win_inv;
          gnt0_d  = ~w_winner;
          gnt1_d  = w_winner;
          cnt_d   = '0;
          state_d = S_ISSUE;
`ifdef ALSU_ARB_PRECHECK_EN
          alsu_cmd_d = w_win_inv ? cmd_t'('0) : w_win_cmd;
`else
          alsu_cmd_d = w_win_cmd;
`endif
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
`ifdef ALSU_ARB_PRECHECK_EN
        // Rejected command never reached the ALSU: report it straight away.
        if (inv_q) begin
          done0_d    = ~owner_q;
          done1_d    = owner_q;
          err_d      = 1'b1;
          alsu_cmd_d = '0;
          state_d    = S_IDLE;
        end
`endif
      end

      S_WAIT: begin
        if (cnt_q == c_WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        if (inv_q) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          result_d   = bus.alsu_out;
          err_d      = 1'b0;
          done0_d    = ~owner_q;
          done1_d    = owner_q;
          alsu_cmd_d = '0;
          state_d    = S_IDLE;
        end
      end

      // ALSU is blinking its LED; keep the command on the bus and stay blocked.
      S_HOLD: begin
        if (cnt_q == c_HOLD_LAST) begin
          err_d      = 1'b1;
          done0_d    = ~owner_q;
          done1_d    = owner_q;
          alsu_cmd_d = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        alsu_cmd_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;   // so requester 0 wins the first contention
      inv_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      alsu_cmd_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      inv_q      <= inv_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      result_q   <= result_d;
      err_q      <= err_d;
      alsu_cmd_q <= alsu_cmd_d;
    end
  end

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;
  assign bus.result         = result_q;
  assign bus.err            = err_q;
  assign bus.alsu_A         = alsu_cmd_q.a;
  assign bus.alsu_B         = alsu_cmd_q.b;
  assign bus.alsu_opcode    = alsu_cmd_q.opcode;
  assign bus.alsu_cin       = alsu_cmd_q.cin;
  assign bus.alsu_serial_in = alsu_cmd_q.serial_in;
  assign bus.alsu_direction = alsu_cmd_q.direction;
  assign bus.alsu_red_op_A  = alsu_cmd_q.red_op_a;
  assign bus.alsu_red_op_B  = alsu_cmd_q.red_op_b;
  assign bus.alsu_bypass_A  = alsu_cmd_q.bypass_a;
  assign bus.alsu_bypass_B  = alsu_cmd_q.bypass_b;

endmodule
`default_nettype wire
